// File: rtl/cw_link_tx.sv
// cw_link_tx: clockwise ring link transmitter with a packet FIFO and a hop-shifting send FSM
module cw_link_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 2,
    parameter int HOP_MSB    = 55,
    parameter int HOP_LSB    = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pesi,
    input  logic [DATA_WIDTH-1:0] pedi,
    output logic                  peri,
    output logic                  cwso,
    output logic [DATA_WIDTH-1:0] cwdo,
    input  logic                  cwro,
    output logic                  hop_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, HOLD = 2'd2} state_t;
    state_t                  r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [AW:0]             r_wp, r_rp;
    logic                    w_full, w_empty, w_push, w_pop;
    logic [DATA_WIDTH-1:0]   w_head, w_fwd, w_cwdo_nxt, r_cwdo;
    logic [HOP_MSB-HOP_LSB:0] w_hop;
    logic                    w_cwso_nxt, w_err_nxt, r_cwso, r_hop_err;
    assign w_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_empty = r_wp == r_rp;
    assign peri    = rst && !w_full;
    assign w_push  = pesi && peri;
    assign w_pop   = (r_state == IDLE) && !w_empty && cwro;
    assign w_head  = r_mem[r_rp[AW-1:0]];
    assign w_hop   = w_head[HOP_MSB:HOP_LSB];
    assign cwso    = r_cwso;
    assign cwdo    = r_cwdo;
    assign hop_err = r_hop_err;
    // head packet as it goes on the link: hop field halved, every other bit untouched
    always_comb begin
        w_fwd = w_head;
        w_fwd[HOP_MSB:HOP_LSB] = w_hop >> 1;
    end
    // FIFO storage; stale entries are never read, so no reset is needed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= pedi;
    end
    // read/write pointers with an extra wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
        end
    end
    // send FSM next state and next link outputs; SEND and HOLD pace the link to one packet per 3 cycles
    always_comb begin
        w_state_nxt = r_state;
        w_cwso_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_cwdo_nxt  = r_cwdo;
        case (r_state)
            IDLE: if (w_pop) begin
                if (w_hop != '0) begin
                    w_cwdo_nxt  = w_fwd;
                    w_cwso_nxt  = 1'b1;
                    w_state_nxt = SEND;
                end else begin
                    w_err_nxt = 1'b1;
                end
            end
            SEND:    w_state_nxt = HOLD;
            HOLD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
    // FSM state and registered link outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_cwso    <= 1'b0;
            r_cwdo    <= '0;
            r_hop_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cwso    <= w_cwso_nxt;
            r_cwdo    <= w_cwdo_nxt;
            r_hop_err <= w_err_nxt;
        end
    end
endmodule

// File: tb/tb_cw_link_tx.sv
// tb_cw_link_tx: directed table, corner-case sequences and random traffic against a queue model
module tb_cw_link_tx;
    localparam int DW = 64, DEPTH = 2, HM = 55, HL = 48;
    logic          clk = 1'b0, rst = 1'b0, pesi = 1'b0, cwro = 1'b0;
    logic [DW-1:0] pedi = '0;
    logic          peri, cwso, hop_err;
    logic [DW-1:0] cwdo;
    int            n_checks = 0, n_errors = 0, n_sends = 0;
    logic [DW-1:0] mq[$];
    int            cool = 0;
    logic          exp_cwso = 1'b0, exp_err = 1'b0;
    logic [DW-1:0] exp_cwdo = '0;
    typedef struct {
        logic          pesi;
        logic [DW-1:0] pedi;
        logic          cwro;
        logic          e_peri;
        logic          e_cwso;
        logic [DW-1:0] e_cwdo;
        logic          e_err;
    } vec_t;
    vec_t tbl[9];

    always #5 clk = ~clk;

    cw_link_tx #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .HOP_MSB(HM), .HOP_LSB(HL)) dut (
        .clk(clk), .rst(rst), .pesi(pesi), .pedi(pedi), .peri(peri),
        .cwso(cwso), .cwdo(cwdo), .cwro(cwro), .hop_err(hop_err)
    );

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] fwd(input logic [DW-1:0] p);
        logic [7:0] h;
        h = p[HM:HL];
        p[HM:HL] = h / 2;
        return p;
    endfunction

    function automatic logic [DW-1:0] mk(input int hop);
        logic [DW-1:0] p;
        p = {$urandom, $urandom};
        p[HM:HL] = hop[7:0];
        return p;
    endfunction

    // one clock: model decides from pre-edge inputs, then DUT outputs compared 1 time unit after the edge
    task automatic step(output bit pushed);
        bit            do_push, do_pop;
        logic [DW-1:0] d, h;
        do_push = rst && pesi && (mq.size() < DEPTH);
        do_pop  = rst && cwro && (cool == 0) && (mq.size() > 0);
        d = pedi;
        @(posedge clk);
        exp_cwso = 1'b0;
        exp_err  = 1'b0;
        if (!rst) begin
            mq.delete();
            cool = 0;
            exp_cwdo = '0;
        end else begin
            if (do_pop) begin
                h = mq.pop_front();
                if (h[HM:HL] == 8'h00) exp_err = 1'b1;
                else begin
                    exp_cwso = 1'b1;
                    exp_cwdo = fwd(h);
                    cool = 2;
                end
            end else if (cool > 0) cool--;
            if (do_push) mq.push_back(d);
        end
        pushed = do_push;
        #1;
        if (cwso === 1'b1) n_sends++;
        chk("peri", {63'd0, peri}, {63'd0, rst && (mq.size() < DEPTH)});
        chk("cwso", {63'd0, cwso}, {63'd0, exp_cwso});
        chk("cwdo", cwdo, exp_cwdo);
        chk("hop_err", {63'd0, hop_err}, {63'd0, exp_err});
    endtask

    initial begin
        bit p;
        int s0, k;
        tbl[0] = '{1'b1, 64'h0004_AAAA_0000_0001, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0};
        tbl[1] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0002_AAAA_0000_0001, 1'b0};
        tbl[2] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0002_AAAA_0000_0001, 1'b0};
        tbl[3] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h0002_AAAA_0000_0001, 1'b0};
        tbl[4] = '{1'b1, 64'h1200_5555_0000_0011, 1'b1, 1'b1, 1'b0, 64'h0002_AAAA_0000_0001, 1'b0};
        tbl[5] = '{1'b1, 64'h3380_0000_FFFF_0022, 1'b1, 1'b1, 1'b0, 64'h0002_AAAA_0000_0001, 1'b1};
        tbl[6] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h3340_0000_FFFF_0022, 1'b0};
        tbl[7] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h3340_0000_FFFF_0022, 1'b0};
        tbl[8] = '{1'b0, 64'h0, 1'b1, 1'b1, 1'b0, 64'h3340_0000_FFFF_0022, 1'b0};
        // reset state
        #2;
        chk("rst_peri", {63'd0, peri}, 64'd0);
        chk("rst_cwso", {63'd0, cwso}, 64'd0);
        chk("rst_cwdo", cwdo, 64'd0);
        chk("rst_hop_err", {63'd0, hop_err}, 64'd0);
        step(p);
        step(p);
        rst = 1'b1;
        step(p);
        // single packet and hop-zero drop
        for (int i = 0; i < 9; i++) begin
            pesi = tbl[i].pesi;
            pedi = tbl[i].pedi;
            cwro = tbl[i].cwro;
            step(p);
            chk($sformatf("tbl%0d_peri", i), {63'd0, peri}, {63'd0, tbl[i].e_peri});
            chk($sformatf("tbl%0d_cwso", i), {63'd0, cwso}, {63'd0, tbl[i].e_cwso});
            chk($sformatf("tbl%0d_cwdo", i), cwdo, tbl[i].e_cwdo);
            chk($sformatf("tbl%0d_err", i), {63'd0, hop_err}, {63'd0, tbl[i].e_err});
        end
        // backpressure: fill, ignored third push, then drain in order
        s0 = n_sends;
        cwro = 1'b0;
        pesi = 1'b1;
        pedi = 64'h0110_0000_0000_000A;
        step(p);
        pedi = 64'h0220_0000_0000_000B;
        step(p);
        chk("bp_full_peri", {63'd0, peri}, 64'd0);
        pedi = 64'h0330_0000_0000_000C;
        step(p);
        chk("bp_third_ignored", {63'd0, p}, 64'd0);
        pesi = 1'b0;
        step(p);
        cwro = 1'b1;
        repeat (8) step(p);
        chk("bp_sent", n_sends - s0, 64'd2);
        // simultaneous push and pop at occupancy 1
        cwro = 1'b0;
        pesi = 1'b1;
        pedi = 64'h0440_1111_0000_0001;
        step(p);
        cwro = 1'b1;
        pedi = 64'h0550_2222_0000_0002;
        step(p);
        chk("simul_peri", {63'd0, peri}, 64'd1);
        pesi = 1'b0;
        repeat (6) step(p);
        // stream ten packets through the wrapping FIFO
        s0 = n_sends;
        k = 0;
        cwro = 1'b1;
        pesi = 1'b1;
        pedi = mk(1);
        for (int c = 0; c < 100 && k < 10; c++) begin
            step(p);
            if (p) begin
                k++;
                pedi = mk(k + 1);
            end
        end
        pesi = 1'b0;
        repeat (40) step(p);
        chk("stream_pushed", k, 64'd10);
        chk("stream_sent", n_sends - s0, 64'd10);
        // reset asserted in the middle of a send
        pesi = 1'b1;
        pedi = 64'h0004_AAAA_0000_0001;
        step(p);
        pesi = 1'b0;
        step(p);
        rst = 1'b0;
        #1;
        chk("midrst_cwso", {63'd0, cwso}, 64'd0);
        chk("midrst_cwdo", cwdo, 64'd0);
        chk("midrst_hop_err", {63'd0, hop_err}, 64'd0);
        chk("midrst_peri", {63'd0, peri}, 64'd0);
        step(p);
        step(p);
        rst = 1'b1;
        step(p);
        // random traffic with occasional zero hop and stalled receiver
        for (int i = 0; i < 400; i++) begin
            pesi = ($urandom_range(0, 2) != 0);
            pedi = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) pedi[HM:HL] = 8'h00;
            cwro = ($urandom_range(0, 3) != 0);
            step(p);
        end
        pesi = 1'b0;
        cwro = 1'b1;
        repeat (10) step(p);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
